spi_master_param: RTL and testbench

Parametrised SPI master, the successor to the fixed-format generator_spi. It adds configurable word width, several chip selects, run-time selection of all four CKP/CPH modes, a programmable SCK divider, selectable bit order and a start/busy/done handshake toward the host logic. It drives SCK/MOSI/CS to receptor_spi-style targets and captures MISO.

---
 rtl/spi_master_param.sv | 182 ++++++++++++++++++
 tb/tb_spi_master_param.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_param.sv
// Parametrised SPI master: configurable word width, chip selects, CKP/CPH mode,
// SCK divider and bit order, with a start/busy/done handshake toward the host.
module spi_master_param #(
  parameter int DATA_W   = 8,
  parameter int NUM_CS   = 2,
  parameter int CS_SEL_W = 1,
  parameter int DIV_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [DATA_W-1:0]   tx_data,
  input  logic [CS_SEL_W-1:0] cs_sel,
  input  logic                CKP,
  input  logic                CPH,
  input  logic [DIV_W-1:0]    clk_div,
  input  logic                msb_first,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   rx_data,
  output logic                SCK,
  output logic                MOSI,
  input  logic                MISO,
  output logic [NUM_CS-1:0]   CS
);

  localparam int HP_W = $clog2(2 * DATA_W);
  localparam logic [HP_W-1:0] HP_LAST = HP_W'(2 * DATA_W - 1);
  localparam logic [CS_SEL_W:0] NUM_CS_L = (CS_SEL_W + 1)'(NUM_CS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    TRANSFER = 2'd2,
    HOLD     = 2'd3
  } state_t;

  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic msb);
    return msb ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic msb);
    return msb ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b,
                                                 input logic msb);
    return msb ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
  endfunction

  state_t              state_r, state_nxt_s;
  logic [DIV_W-1:0]    cnt_r, cnt_nxt_s, div_r, div_nxt_s;
  logic [HP_W-1:0]     hp_r, hp_nxt_s, hp_next_s;
  logic [DATA_W-1:0]   tx_r, tx_nxt_s, rx_r, rx_nxt_s, rx_data_r, rx_data_nxt_s;
  logic                ckp_r, ckp_nxt_s, cph_r, cph_nxt_s, msb_r, msb_nxt_s;
  logic                sck_r, sck_nxt_s, mosi_r, mosi_nxt_s;
  logic                busy_r, busy_nxt_s, done_r, done_nxt_s;
  logic [NUM_CS-1:0]   cs_r, cs_nxt_s, cs_dec_s;
  logic                start_ok_s, phase_end_s, edge_s, sample_s, emit_s;

  // hp_r indexes SCK half-periods inside TRANSFER; even ones sit at the leading level
  assign start_ok_s  = start && ({1'b0, cs_sel} < NUM_CS_L);
  assign phase_end_s = (cnt_r == div_r);
  assign hp_next_s   = (state_r == SETUP) ? '0 : hp_r + 1'b1;
  assign edge_s      = phase_end_s && ((state_r == SETUP) ||
                       ((state_r == TRANSFER) && (hp_r != HP_LAST)));
  assign sample_s    = edge_s && (cph_r ? hp_next_s[0] : !hp_next_s[0]);
  assign emit_s      = edge_s && (cph_r ? !hp_next_s[0] :
                       (hp_next_s[0] && (hp_next_s != HP_LAST)));

  assign SCK     = sck_r;
  assign MOSI    = mosi_r;
  assign CS      = cs_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign rx_data = rx_data_r;

  // Active-low one-hot decode of the requested chip select
  always_comb begin
    cs_dec_s = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (cs_sel == CS_SEL_W'(i)) cs_dec_s[i] = 1'b0;
      else                        cs_dec_s[i] = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:     state_nxt_s = start_ok_s ? SETUP : IDLE;
      SETUP:    state_nxt_s = phase_end_s ? TRANSFER : SETUP;
      TRANSFER: state_nxt_s = (phase_end_s && (hp_r == HP_LAST)) ? HOLD : TRANSFER;
      HOLD:     state_nxt_s = phase_end_s ? IDLE : HOLD;
      default:  state_nxt_s = IDLE;
    endcase
  end

  // Next values of the datapath and the registered outputs
  always_comb begin
    cnt_nxt_s = cnt_r;     hp_nxt_s   = hp_r;     tx_nxt_s   = tx_r;
    rx_nxt_s  = rx_r;      div_nxt_s  = div_r;    ckp_nxt_s  = ckp_r;
    cph_nxt_s = cph_r;     msb_nxt_s  = msb_r;    sck_nxt_s  = sck_r;
    mosi_nxt_s = mosi_r;   cs_nxt_s   = cs_r;     busy_nxt_s = busy_r;
    done_nxt_s = 1'b0;     rx_data_nxt_s = rx_data_r;
    case (state_r)
      IDLE: begin
        sck_nxt_s = CKP;
        if (start_ok_s) begin
          cnt_nxt_s  = '0;       hp_nxt_s  = '0;      rx_nxt_s  = '0;
          div_nxt_s  = clk_div;  ckp_nxt_s = CKP;     cph_nxt_s = CPH;
          msb_nxt_s  = msb_first;
          busy_nxt_s = 1'b1;
          cs_nxt_s   = cs_dec_s;
          // Leading-edge sampling needs the first bit on the wire before SCK moves
          if (!CPH) begin
            mosi_nxt_s = first_bit(tx_data, msb_first);
            tx_nxt_s   = shift_out(tx_data, msb_first);
          end else begin
            tx_nxt_s   = tx_data;
          end
        end else begin
          busy_nxt_s = 1'b0;
        end
      end
      SETUP, TRANSFER: begin
        cnt_nxt_s = phase_end_s ? '0 : cnt_r + 1'b1;
        if (edge_s) begin
          hp_nxt_s  = hp_next_s;
          sck_nxt_s = ckp_r ^ !hp_next_s[0];
        end else begin
          hp_nxt_s  = hp_r;
        end
        if (sample_s) rx_nxt_s = shift_in(rx_r, MISO, msb_r);
        else          rx_nxt_s = rx_r;
        if (emit_s) begin
          mosi_nxt_s = first_bit(tx_r, msb_r);
          tx_nxt_s   = shift_out(tx_r, msb_r);
        end else begin
          mosi_nxt_s = mosi_r;
        end
      end
      HOLD: begin
        cnt_nxt_s = phase_end_s ? '0 : cnt_r + 1'b1;
        if (phase_end_s) begin
          cs_nxt_s      = '1;
          done_nxt_s    = 1'b1;
          busy_nxt_s    = 1'b0;
          rx_data_nxt_s = rx_r;
        end else begin
          done_nxt_s    = 1'b0;
        end
      end
      default: begin
        cs_nxt_s   = '1;
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;  hp_r <= '0;  tx_r <= '0;  rx_r <= '0;  div_r <= '0;
      ckp_r <= 1'b0;  cph_r <= 1'b0;  msb_r <= 1'b0;
      sck_r <= 1'b0;  mosi_r <= 1'b0;  cs_r <= '1;
      busy_r <= 1'b0;  done_r <= 1'b0;  rx_data_r <= '0;
    end else begin
      cnt_r <= cnt_nxt_s;  hp_r <= hp_nxt_s;  tx_r <= tx_nxt_s;  rx_r <= rx_nxt_s;
      div_r <= div_nxt_s;  ckp_r <= ckp_nxt_s;  cph_r <= cph_nxt_s;  msb_r <= msb_nxt_s;
      sck_r <= sck_nxt_s;  mosi_r <= mosi_nxt_s;  cs_r <= cs_nxt_s;
      busy_r <= busy_nxt_s;  done_r <= done_nxt_s;  rx_data_r <= rx_data_nxt_s;
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Directed self-checking bench for spi_master_param: modes, bit order,
// back-to-back handshake, reset abort and invalid chip-select requests.
module tb_spi_master_param;
  localparam int DW = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [1:0] cs_sel = 2'd0;
  logic       CKP = 1'b0;
  logic       CPH = 1'b0;
  logic [7:0] clk_div = 8'd0;
  logic       msb_first = 1'b1;
  logic       busy, done, SCK, MOSI, MISO;
  logic [7:0] rx_data;
  logic [1:0] CS;

  int tests = 0;
  int fails = 0;

  // slave model: loopback or shift out slave_word, advancing on trailing edges
  logic       loopback = 1'b1;
  logic [7:0] slave_word = 8'h00;
  logic       slave_msb = 1'b1;
  logic       cfg_ckp = 1'b0;
  logic       slave_bit;
  logic       sl_prev_sck = 1'b0;
  int         sl_cnt = 0;

  int   m_edges, m_cs_low, m_other_low, m_done, m_lat, m_first_edge, m_bad_mosi;
  logic m_first_mosi;

  spi_master_param #(.DATA_W(8), .NUM_CS(2), .CS_SEL_W(2), .DIV_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .tx_data(tx_data), .cs_sel(cs_sel),
    .CKP(CKP), .CPH(CPH), .clk_div(clk_div), .msb_first(msb_first),
    .busy(busy), .done(done), .rx_data(rx_data), .SCK(SCK), .MOSI(MOSI),
    .MISO(MISO), .CS(CS)
  );

  always #5 clk = ~clk;

  always @(SCK or CS) begin
    if (CS == 2'b11) sl_cnt = 0;
    else if (SCK !== sl_prev_sck && SCK == cfg_ckp) sl_cnt = sl_cnt + 1;
    sl_prev_sck = SCK;
  end

  always @* begin
    if (sl_cnt < DW) slave_bit = slave_msb ? slave_word[DW-1-sl_cnt] : slave_word[sl_cnt];
    else             slave_bit = 1'b0;
  end

  assign MISO = loopback ? MOSI : slave_bit;

  task automatic do_xfer(input logic [7:0] tx, input logic [1:0] sel, input logic ckp,
                         input logic cph, input logic [7:0] div, input logic msb,
                         input logic lb, input logic [7:0] sw);
    logic prev_sck, prev_mosi, ok;
    int   k;
    bit   got;
    @(negedge clk);
    tx_data = tx; cs_sel = sel; CKP = ckp; CPH = cph; clk_div = div; msb_first = msb;
    loopback = lb; slave_word = sw; slave_msb = msb; cfg_ckp = ckp;
    repeat (2) @(negedge clk);
    prev_sck = SCK; prev_mosi = MOSI; start = 1'b1;
    m_edges = 0; m_cs_low = 0; m_other_low = 0; m_done = 0; m_lat = 0;
    m_first_edge = 0; m_bad_mosi = 0; m_first_mosi = 1'b0;
    k = 0; got = 1'b0;
    while (!got && k < 3000) begin
      @(negedge clk);
      start = 1'b0;
      k++;
      if (SCK !== prev_sck) begin
        m_edges++;
        if (m_edges == 1) begin m_first_edge = k; m_first_mosi = MOSI; end
      end
      if (MOSI !== prev_mosi) begin
        ok = cph ? (SCK !== prev_sck && SCK === ~ckp)
                 : ((SCK !== prev_sck && SCK === ckp) || k == 1);
        if (!ok) m_bad_mosi++;
      end
      for (int i = 0; i < 2; i++) begin
        if (CS[i] === 1'b0) begin
          if (i == int'(sel)) m_cs_low++;
          else                m_other_low++;
        end
      end
      if (done === 1'b1) begin m_done++; m_lat = k; got = 1'b1; end
      prev_sck = SCK; prev_mosi = MOSI;
    end
    tests++;
    if (!got) begin fails++; $display("FAIL xfer_timeout: no done within %0d cycles", k); end
    repeat (2) begin
      @(negedge clk);
      if (done === 1'b1) m_done++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests += 6;
    if (SCK !== 1'b0)     begin fails++; $display("FAIL rst_sck: got %b expected 0", SCK); end
    if (MOSI !== 1'b0)    begin fails++; $display("FAIL rst_mosi: got %b expected 0", MOSI); end
    if (CS !== 2'b11)     begin fails++; $display("FAIL rst_cs: got %b expected 11", CS); end
    if (busy !== 1'b0)    begin fails++; $display("FAIL rst_busy: got %b expected 0", busy); end
    if (done !== 1'b0)    begin fails++; $display("FAIL rst_done: got %b expected 0", done); end
    if (rx_data !== 8'h00) begin fails++; $display("FAIL rst_rx: got %h expected 00", rx_data); end
    reset = 1'b0;
  endtask

  task automatic test_mode0;
    do_xfer(8'hA5, 2'd0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b1, 8'h00);
    tests += 8;
    if (m_edges != 16)      begin fails++; $display("FAIL m0_edges: got %0d expected 16", m_edges); end
    if (m_cs_low != 36)     begin fails++; $display("FAIL m0_cs_low: got %0d expected 36", m_cs_low); end
    if (rx_data !== 8'hA5)  begin fails++; $display("FAIL m0_rx: got %h expected a5", rx_data); end
    if (m_done != 1)        begin fails++; $display("FAIL m0_done_pulses: got %0d expected 1", m_done); end
    if (m_other_low != 0)   begin fails++; $display("FAIL m0_cs1_low: got %0d expected 0", m_other_low); end
    if (m_lat != 37)        begin fails++; $display("FAIL m0_latency: got %0d expected 37", m_lat); end
    if (m_first_edge != 3)  begin fails++; $display("FAIL m0_first_edge: got %0d expected 3", m_first_edge); end
    if (m_bad_mosi != 0)    begin fails++; $display("FAIL m0_mosi_timing: got %0d expected 0", m_bad_mosi); end
  endtask

  task automatic test_mode3;
    do_xfer(8'h3C, 2'd0, 1'b1, 1'b1, 8'd0, 1'b1, 1'b0, 8'hC3);
    tests += 5;
    if (rx_data !== 8'hC3)  begin fails++; $display("FAIL m3_rx: got %h expected c3", rx_data); end
    if (m_cs_low != 18)     begin fails++; $display("FAIL m3_cs_low: got %0d expected 18", m_cs_low); end
    if (m_bad_mosi != 0)    begin fails++; $display("FAIL m3_mosi_timing: got %0d expected 0", m_bad_mosi); end
    if (m_edges != 16)      begin fails++; $display("FAIL m3_edges: got %0d expected 16", m_edges); end
    if (SCK !== 1'b1)       begin fails++; $display("FAIL m3_sck_idle: got %b expected 1", SCK); end
  endtask

  task automatic test_modes12;
    for (int m = 1; m <= 2; m++) begin
      do_xfer(8'h5A, 2'd1, (m == 2), (m == 1), 8'd2, 1'b1, 1'b1, 8'h00);
      tests += 4;
      if (rx_data !== 8'h5A) begin fails++; $display("FAIL m%0d_rx: got %h expected 5a", m, rx_data); end
      if (m_bad_mosi != 0)   begin fails++; $display("FAIL m%0d_mosi_timing: got %0d expected 0", m, m_bad_mosi); end
      if (m_edges != 16)     begin fails++; $display("FAIL m%0d_edges: got %0d expected 16", m, m_edges); end
      if (m_cs_low != 54)    begin fails++; $display("FAIL m%0d_cs_low: got %0d expected 54", m, m_cs_low); end
    end
  endtask

  task automatic test_lsb_first;
    do_xfer(8'h01, 2'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'h80);
    tests += 2;
    if (m_first_mosi !== 1'b1) begin fails++; $display("FAIL lsb_first_mosi: got %b expected 1", m_first_mosi); end
    if (rx_data !== 8'h80)     begin fails++; $display("FAIL lsb_rx: got %h expected 80", rx_data); end
  endtask

  task automatic test_back_to_back;
    int k, busy_cycles;
    @(negedge clk);
    tx_data = 8'h96; cs_sel = 2'd0; CKP = 1'b0; CPH = 1'b0; clk_div = 8'd0;
    msb_first = 1'b1; loopback = 1'b1; cfg_ckp = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    cs_sel = 2'd1; tx_data = 8'h3E;
    k = 1;
    while (done !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    tests += 5;
    if (k != 19)           begin fails++; $display("FAIL b2b_latency: got %0d expected 19", k); end
    if (CS !== 2'b11)      begin fails++; $display("FAIL b2b_gap_cs: got %b expected 11", CS); end
    if (rx_data !== 8'h96) begin fails++; $display("FAIL b2b_rx1: got %h expected 96", rx_data); end
    @(negedge clk);
    if (CS !== 2'b01)      begin fails++; $display("FAIL b2b_cs1: got %b expected 01", CS); end
    if (busy !== 1'b1)     begin fails++; $display("FAIL b2b_busy: got %b expected 1", busy); end
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    tests += 3;
    if (k >= 100)          begin fails++; $display("FAIL b2b_timeout: no second done"); end
    if (rx_data !== 8'h3E) begin fails++; $display("FAIL b2b_rx2: got %h expected 3e", rx_data); end
    busy_cycles = 0;
    repeat (30) begin @(negedge clk); if (busy !== 1'b0) busy_cycles++; end
    if (busy_cycles != 0)  begin fails++; $display("FAIL b2b_extra_xfer: got %0d busy cycles expected 0", busy_cycles); end
  endtask

  task automatic test_abort;
    int k, edges, dones, bad;
    logic prev_sck;
    @(negedge clk);
    tx_data = 8'hF0; cs_sel = 2'd1; CKP = 1'b0; CPH = 1'b0; clk_div = 8'd1;
    msb_first = 1'b1; loopback = 1'b1; cfg_ckp = 1'b0;
    repeat (2) @(negedge clk);
    prev_sck = SCK; start = 1'b1;
    edges = 0; k = 0;
    while (edges < 7 && k < 200) begin
      @(negedge clk); start = 1'b0; k++;
      if (SCK !== prev_sck) edges++;
      prev_sck = SCK;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests += 7;
    if (edges != 7)        begin fails++; $display("FAIL abort_edges: got %0d expected 7", edges); end
    if (CS !== 2'b11)      begin fails++; $display("FAIL abort_cs: got %b expected 11", CS); end
    if (SCK !== 1'b0)      begin fails++; $display("FAIL abort_sck: got %b expected 0", SCK); end
    if (busy !== 1'b0)     begin fails++; $display("FAIL abort_busy: got %b expected 0", busy); end
    if (MOSI !== 1'b0)     begin fails++; $display("FAIL abort_mosi: got %b expected 0", MOSI); end
    if (rx_data !== 8'h00) begin fails++; $display("FAIL abort_rx: got %h expected 00", rx_data); end
    dones = 0;
    repeat (60) begin @(negedge clk); if (done !== 1'b0) dones++; end
    if (dones != 0)        begin fails++; $display("FAIL abort_done: got %0d pulses expected 0", dones); end
    cs_sel = 2'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bad = 0;
    repeat (40) begin @(negedge clk); if (busy !== 1'b0 || CS !== 2'b11) bad++; end
    tests++;
    if (bad != 0)          begin fails++; $display("FAIL bad_sel_ignored: got %0d active cycles expected 0", bad); end
    do_xfer(8'h69, 2'd1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'h00);
    tests += 3;
    if (rx_data !== 8'h69) begin fails++; $display("FAIL after_abort_rx: got %h expected 69", rx_data); end
    if (m_done != 1)       begin fails++; $display("FAIL after_abort_done: got %0d expected 1", m_done); end
    if (m_lat != 19)       begin fails++; $display("FAIL after_abort_latency: got %0d expected 19", m_lat); end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode3();
    test_modes12();
    test_lsb_first();
    test_back_to_back();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
